// File: rtl/byte_ram.sv
// Synchronous word RAM with byte write strobes, registered read port and a
// post-reset clear sweep. Define BYTE_RAM_BYPASS_EN for write-first collisions.
module byte_ram #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 256,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int NBYTES     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [NBYTES-1:0]     wstrb,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  ready
);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    localparam logic [ADDR_WIDTH:0]   DepthExt  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic                  waddrInRange;
    logic                  raddrInRange;
    logic                  clearWe;
    logic                  userWe;
    logic [DATA_WIDTH-1:0] readWord;

    assign waddrInRange = ({1'b0, waddr} < DepthExt);
    assign raddrInRange = ({1'b0, raddr} < DepthExt);
    assign clearWe      = (state_q == CLEAR);
    assign userWe       = (state_q == READY) && wen && waddrInRange;

    // Same-address collisions either see the old word or the strobe-merged word.
    always_comb begin
        readWord = '0;
        if (raddrInRange) begin
            readWord = mem_q[raddr];
`ifdef BYTE_RAM_BYPASS_EN
            if (userWe && (waddr == raddr)) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (wstrb[i]) begin
                        readWord[8*i +: 8] = wdata[8*i +: 8];
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LastAddr) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                if (ren) begin
                    rvalid_d = 1'b1;
                    rdata_d  = readWord;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage is never touched while reset is held; the clear sweep owns it until READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (clearWe) begin
                mem_q[cnt_q] <= '0;
            end else if (userWe) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (wstrb[i]) begin
                        mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign ready  = (state_q == READY);

endmodule

// File: tb/tb_byte_ram.sv
// Scoreboard bench for byte_ram: reads push their expected word, a negedge
// monitor pops and compares whenever rvalid is seen.
module tb_byte_ram;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [3:0]  wstrb;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic        rvalid;
    logic        ready;

    logic [31:0] expQ [$];
    int          compared;
    int          mismatched;

    byte_ram #(
        .DATA_WIDTH(32),
        .DEPTH(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wen(wen),
        .wstrb(wstrb),
        .waddr(waddr),
        .wdata(wdata),
        .ren(ren),
        .raddr(raddr),
        .rdata(rdata),
        .rvalid(rvalid),
        .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the value the bench worked out.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one access for a single rising edge, then return the bus to idle.
    task automatic applyStimulus(input logic w, input logic [3:0] s, input logic [7:0] wa,
                                 input logic [31:0] wd, input logic r, input logic [7:0] ra);
        wen   = w;
        wstrb = s;
        waddr = wa;
        wdata = wd;
        ren   = r;
        raddr = ra;
        @(posedge clk);
        #1;
        wen   = 1'b0;
        wstrb = 4'b0;
        ren   = 1'b0;
    endtask

    task automatic doRead(input logic [7:0] ra, input logic [31:0] expected);
        expQ.push_back(expected);
        applyStimulus(1'b0, 4'b0, 8'd0, 32'd0, 1'b1, ra);
    endtask

    task automatic doWrite(input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] s);
        applyStimulus(1'b1, s, wa, wd, 1'b0, 8'd0);
    endtask

    // Wait for ready after reset release, returning the number of edges taken.
    task automatic waitReady(output int edges);
        edges = 0;
        while (edges < 1000) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready) break;
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rvalid) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rvalid: got rdata 0x%08h, expected no read", rdata);
            end else begin
                checkOutput("read_data", rdata, expQ.pop_front());
            end
        end
    end

    initial begin
        int edges;
        logic [31:0] collideExp;
        compared   = 0;
        mismatched = 0;
        rst   = 1'b0;
        wen   = 1'b0;
        wstrb = 4'b0;
        waddr = 8'd0;
        wdata = 32'd0;
        ren   = 1'b0;
        raddr = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);

        rst = 1'b1;
        waitReady(edges);
        checkOutput("clear_edges", edges, 32'd256);

        doRead(8'd0, 32'h0000_0000);
        doRead(8'd1, 32'h0000_0000);
        doRead(8'd255, 32'h0000_0000);

        doWrite(8'd1, 32'hDEAD_BEEF, 4'b1111);
        doWrite(8'd1, 32'h0000_00AA, 4'b0001);
        doRead(8'd1, 32'hDEAD_BEAA);

        applyStimulus(1'b0, 4'b0, 8'd0, 32'd0, 1'b0, 8'd0);
        checkOutput("idle_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("idle_rdata_hold", rdata, 32'hDEAD_BEAA);
        checkOutput("ready_held", {31'd0, ready}, 32'd1);

        doWrite(8'd2, 32'h1234_5678, 4'b1100);
        doRead(8'd2, 32'h1234_0000);

        doWrite(8'd1, 32'h0000_0000, 4'b0000);
        doRead(8'd1, 32'hDEAD_BEAA);

        doWrite(8'd3, 32'h1111_1111, 4'b1111);
`ifdef BYTE_RAM_BYPASS_EN
        collideExp = 32'h1111_FFFF;
`else
        collideExp = 32'h1111_1111;
`endif
        expQ.push_back(collideExp);
        applyStimulus(1'b1, 4'b0011, 8'd3, 32'hFFFF_FFFF, 1'b1, 8'd3);
        doRead(8'd3, 32'h1111_FFFF);

        expQ.push_back(32'hDEAD_BEAA);
        applyStimulus(1'b1, 4'b1111, 8'd4, 32'hCAFE_F00D, 1'b1, 8'd1);
        doRead(8'd4, 32'hCAFE_F00D);

        doWrite(8'd255, 32'hA5A5_5A5A, 4'b1111);
        doRead(8'd255, 32'hA5A5_5A5A);

        rst   = 1'b0;
        ren   = 1'b1;
        raddr = 8'd4;
        @(posedge clk);
        #1;
        ren = 1'b0;
        checkOutput("midread_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("midread_rdata", rdata, 32'd0);
        checkOutput("midread_ready", {31'd0, ready}, 32'd0);

        rst = 1'b1;
        waitReady(edges);
        checkOutput("reclear_edges", edges, 32'd256);
        doRead(8'd4, 32'h0000_0000);
        doRead(8'd255, 32'h0000_0000);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drain", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
